// File: rtl/lcd_frame_sched_pkg.sv
// -----------------------------------------------------------------------------
// lcd_frame_sched_pkg
// Shared constants, state/segment enums and helpers for the LCD frame
// scheduler and its frame buffer.
//   - Command bytes understood by the downstream LCD controller.
//   - Substitutions for buffered characters that collide with those commands.
//   - Helper that locates the last non-space column of a line (used only when
//     LCD_FRAME_SCHED_TRIM_EN is defined).
// -----------------------------------------------------------------------------
package lcd_frame_sched_pkg;

    localparam logic [7:0] CMD_CLEAR = 8'h58;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;
    localparam logic [7:0] SUB_X     = 8'h78;
    localparam logic [7:0] SUB_C0    = 8'h20;
    localparam logic [7:0] SPACE     = 8'h20;

    typedef enum logic [3:0] {
        WAIT_RDY,
        IDLE,
        SEND_CLR,
        L1,
        SEND_L2,
        L2,
        ISSUE,
        GUARD,
        WAIT
    } sched_state_e;

    typedef enum logic {
        RET_L1,
        RET_L2
    } ret_seg_e;

    // The controller decodes 8'h58 and 8'hC0 as commands, so buffered
    // characters with those codes are replaced by harmless look-alikes.
    function automatic logic [7:0] lcd_subst(input logic [7:0] c);
        logic [7:0] r;
        r = c;
        if (c == CMD_CLEAR) begin
            r = SUB_X;
        end else if (c == CMD_LINE2) begin
            r = SUB_C0;
        end
        return r;
    endfunction

    // Returns {found, column} of the highest non-space column of a line.
    function automatic logic [4:0] last_nonspace(input logic [15:0] is_space);
        logic [4:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            if (!is_space[i]) begin
                res = {1'b1, 4'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/lcd_frame_scheduler_buf.sv
// -----------------------------------------------------------------------------
// lcd_frame_buf
// 2x16 character frame buffer, 32 bytes, address = {line, column}.
// Ports:
//   CLK_27, RESET        clock, synchronous active-high reset (all bytes -> space)
//   a_wr_i/a_addr_i/a_data_i  write port A (wins on an address collision)
//   b_wr_i/b_addr_i/b_data_i  write port B
//   rd_addr_i/rd_data_o  asynchronous read port
//   space_o              per-byte "is space" map, only when
//                        LCD_FRAME_SCHED_TRIM_EN is defined
// -----------------------------------------------------------------------------
module lcd_frame_buf
    import lcd_frame_sched_pkg::*;
(
    input  logic        CLK_27,
    input  logic        RESET,
    input  logic        a_wr_i,
    input  logic [4:0]  a_addr_i,
    input  logic [7:0]  a_data_i,
    input  logic        b_wr_i,
    input  logic [4:0]  b_addr_i,
    input  logic [7:0]  b_data_i,
    input  logic [4:0]  rd_addr_i,
    output logic [7:0]  rd_data_o
`ifdef LCD_FRAME_SCHED_TRIM_EN
    ,
    output logic [31:0] space_o
`endif
);

    logic [7:0] mem_q [32];

    // Port A is written after port B so that A takes priority on a collision.
    always_ff @(posedge CLK_27) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= SPACE;
            end
        end else begin
            if (b_wr_i) begin
                mem_q[b_addr_i] <= b_data_i;
            end
            if (a_wr_i) begin
                mem_q[a_addr_i] <= a_data_i;
            end
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

`ifdef LCD_FRAME_SCHED_TRIM_EN
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            space_o[i] = (mem_q[i] == SPACE);
        end
    end
`endif

endmodule

// File: rtl/lcd_frame_scheduler.sv
// -----------------------------------------------------------------------------
// lcd_frame_scheduler
// Holds a 2x16 character frame and replays it to the LCD byte interface
// whenever the frame changes (or on refresh_req): clear, 16 line-1 chars,
// line-2 command, 16 line-2 chars. Every byte is paced on MBusy.
// Ports:
//   CLK_27, RESET               clock, synchronous active-high reset
//   a_wr/a_line/a_col/a_char    requester A character write (priority)
//   b_wr/b_line/b_col/b_char    requester B character write
//   refresh_req                 force a refresh of a clean frame
//   MBusy                       busy flag from the LCD controller
//   Lcd_data, lcdstrb           byte and one-cycle byte strobe
//   sched_busy                  high outside IDLE
//   frame_done                  one-cycle pulse after the last byte of a frame
// Parameters:
//   GUARD_CYC  cycles after each strobe before MBusy is looked at (>= 1)
//   READY_CYC  consecutive MBusy-low cycles needed after reset
// Build option:
//   LCD_FRAME_SCHED_TRIM_EN  skip the trailing spaces of each line
//
// state    | meaning
// WAIT_RDY | after reset, waiting for READY_CYC quiet MBusy cycles
// IDLE     | frame sent; waiting for a dirty buffer or refresh_req
// SEND_CLR | strobe the clear/home command
// L1       | start of line-1 segment (column reset, trim decision)
// SEND_L2  | strobe the line-2 command
// L2       | start of line-2 segment (column reset, trim decision)
// ISSUE    | strobe one character, read live from the buffer
// GUARD    | GUARD_CYC cycles of hold-off after a strobe
// WAIT     | wait for MBusy low, then pick the next byte
// -----------------------------------------------------------------------------
module lcd_frame_scheduler
    import lcd_frame_sched_pkg::*;
#(
    parameter int GUARD_CYC = 4,
    parameter int READY_CYC = 16
) (
    input  logic       CLK_27,
    input  logic       RESET,
    input  logic       a_wr,
    input  logic       a_line,
    input  logic [3:0] a_col,
    input  logic [7:0] a_char,
    input  logic       b_wr,
    input  logic       b_line,
    input  logic [3:0] b_col,
    input  logic [7:0] b_char,
    input  logic       refresh_req,
    input  logic       MBusy,
    output logic [7:0] Lcd_data,
    output logic       lcdstrb,
    output logic       sched_busy,
    output logic       frame_done
);

    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam int RW = (READY_CYC > 1) ? $clog2(READY_CYC) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC - 1);
    localparam logic [RW-1:0] READY_LOAD = RW'(READY_CYC - 1);

    sched_state_e  state_q, state_d;
    ret_seg_e      ret_q, ret_d;
    logic [3:0]    col_q, col_d;
    logic [3:0]    last_col_q, last_col_d;
    logic          seg_entry_q, seg_entry_d;
    logic [GW-1:0] guard_q, guard_d;
    logic [RW-1:0] rdy_q, rdy_d;
    logic          dirty_q, dirty_d;
    logic          frame_done_q, frame_done_d;

    logic [4:0]    rd_addr;
    logic [7:0]    rd_data;
    logic          seg_has_chars;
    logic [3:0]    seg_last_col;

    assign rd_addr = {(ret_q == RET_L2), col_q};

`ifdef LCD_FRAME_SCHED_TRIM_EN
    logic [31:0] space_map;
    logic [15:0] line_space;
    logic [4:0]  trim_res;

    lcd_frame_buf u_buf (
        .CLK_27    (CLK_27),
        .RESET     (RESET),
        .a_wr_i    (a_wr),
        .a_addr_i  ({a_line, a_col}),
        .a_data_i  (a_char),
        .b_wr_i    (b_wr),
        .b_addr_i  ({b_line, b_col}),
        .b_data_i  (b_char),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .space_o   (space_map)
    );

    // Decided once per segment, in L1/L2, against the buffer at that moment.
    always_comb begin
        line_space    = (ret_q == RET_L2) ? space_map[31:16] : space_map[15:0];
        trim_res      = last_nonspace(line_space);
        seg_has_chars = trim_res[4];
        seg_last_col  = trim_res[3:0];
    end
`else
    lcd_frame_buf u_buf (
        .CLK_27    (CLK_27),
        .RESET     (RESET),
        .a_wr_i    (a_wr),
        .a_addr_i  ({a_line, a_col}),
        .a_data_i  (a_char),
        .b_wr_i    (b_wr),
        .b_addr_i  ({b_line, b_col}),
        .b_data_i  (b_char),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign seg_has_chars = 1'b1;
    assign seg_last_col  = 4'hF;
`endif

    always_ff @(posedge CLK_27) begin
        if (RESET) begin
            state_q      <= WAIT_RDY;
            ret_q        <= RET_L1;
            col_q        <= '0;
            last_col_q   <= 4'hF;
            seg_entry_q  <= 1'b0;
            guard_q      <= '0;
            rdy_q        <= READY_LOAD;
            dirty_q      <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            col_q        <= col_d;
            last_col_q   <= last_col_d;
            seg_entry_q  <= seg_entry_d;
            guard_q      <= guard_d;
            rdy_q        <= rdy_d;
            dirty_q      <= dirty_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        col_d        = col_q;
        last_col_d   = last_col_q;
        seg_entry_d  = seg_entry_q;
        guard_d      = guard_q;
        rdy_d        = rdy_q;
        dirty_d      = dirty_q | a_wr | b_wr;
        frame_done_d = 1'b0;
        Lcd_data     = '0;
        lcdstrb      = 1'b0;

        unique case (state_q)
            WAIT_RDY: begin
                if (MBusy) begin
                    rdy_d = READY_LOAD;
                end else if (rdy_q == '0) begin
                    state_d = IDLE;
                end else begin
                    rdy_d = rdy_q - 1'b1;
                end
            end
            IDLE: begin
                if (dirty_q || refresh_req) begin
                    state_d = SEND_CLR;
                    // A write landing in this very cycle must still re-arm.
                    dirty_d = a_wr | b_wr;
                end
            end
            SEND_CLR: begin
                Lcd_data    = CMD_CLEAR;
                lcdstrb     = 1'b1;
                ret_d       = RET_L1;
                seg_entry_d = 1'b1;
                guard_d     = GUARD_LOAD;
                state_d     = GUARD;
            end
            SEND_L2: begin
                Lcd_data    = CMD_LINE2;
                lcdstrb     = 1'b1;
                ret_d       = RET_L2;
                seg_entry_d = 1'b1;
                guard_d     = GUARD_LOAD;
                state_d     = GUARD;
            end
            L1, L2: begin
                col_d      = '0;
                last_col_d = seg_last_col;
                if (seg_has_chars) begin
                    state_d = ISSUE;
                end else if (state_q == L1) begin
                    state_d = SEND_L2;
                end else begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            ISSUE: begin
                Lcd_data    = lcd_subst(rd_data);
                lcdstrb     = 1'b1;
                seg_entry_d = 1'b0;
                guard_d     = GUARD_LOAD;
                state_d     = GUARD;
            end
            GUARD: begin
                if (guard_q == '0) begin
                    state_d = WAIT;
                end else begin
                    guard_d = guard_q - 1'b1;
                end
            end
            WAIT: begin
                if (!MBusy) begin
                    if (seg_entry_q) begin
                        state_d = (ret_q == RET_L1) ? L1 : L2;
                    end else if (col_q == last_col_q) begin
                        col_d = '0;
                        if (ret_q == RET_L1) begin
                            state_d = SEND_L2;
                        end else begin
                            frame_done_d = 1'b1;
                            state_d      = IDLE;
                        end
                    end else begin
                        col_d   = col_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                state_d = WAIT_RDY;
            end
        endcase
    end

    assign sched_busy = (state_q != IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
module tb_lcd_frame_scheduler;

    localparam int GUARD_CYC = 4;
    localparam int READY_CYC = 16;

    logic       CLK_27 = 1'b0;
    logic       RESET = 1'b1;
    logic       a_wr = 1'b0, a_line = 1'b0, b_wr = 1'b0, b_line = 1'b0;
    logic [3:0] a_col = '0, b_col = '0;
    logic [7:0] a_char = '0, b_char = '0;
    logic       refresh_req = 1'b0, MBusy = 1'b0;
    logic [7:0] Lcd_data;
    logic       lcdstrb, sched_busy, frame_done;

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;
    int last_strb = -1000;
    int fd_cnt = 0;
    int l2_start = 0;
    logic [7:0] strb_log[$];
    int         strb_cyc[$];
    logic [7:0] model[32];
    logic [7:0] exp_q[$];

    lcd_frame_scheduler #(
        .GUARD_CYC (GUARD_CYC),
        .READY_CYC (READY_CYC)
    ) dut (
        .CLK_27      (CLK_27),
        .RESET       (RESET),
        .a_wr        (a_wr),
        .a_line      (a_line),
        .a_col       (a_col),
        .a_char      (a_char),
        .b_wr        (b_wr),
        .b_line      (b_line),
        .b_col       (b_col),
        .b_char      (b_char),
        .refresh_req (refresh_req),
        .MBusy       (MBusy),
        .Lcd_data    (Lcd_data),
        .lcdstrb     (lcdstrb),
        .sched_busy  (sched_busy),
        .frame_done  (frame_done)
    );

    always #5 CLK_27 = ~CLK_27;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe logger: every strobe is recorded and its spacing checked.
    always @(posedge CLK_27) begin
        #1;
        cyc_n++;
        if (lcdstrb === 1'b1) begin
            chk("strb_min_gap", 32'((cyc_n - last_strb) >= GUARD_CYC + 1), 32'd1);
            last_strb = cyc_n;
            strb_log.push_back(Lcd_data);
            strb_cyc.push_back(cyc_n);
        end
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic tick();
        @(posedge CLK_27);
        #2;
    endtask

    function automatic logic [7:0] subst(input logic [7:0] c);
        if (c == 8'h58) return 8'h78;
        if (c == 8'hC0) return 8'h20;
        return c;
    endfunction

    function automatic void push_line(input int ln);
        int n;
        n = 16;
`ifdef LCD_FRAME_SCHED_TRIM_EN
        n = 0;
        for (int c = 0; c < 16; c++) if (model[ln*16+c] != 8'h20) n = c + 1;
`endif
        for (int c = 0; c < n; c++) exp_q.push_back(subst(model[ln*16+c]));
    endfunction

    function automatic void build_exp();
        exp_q.delete();
        exp_q.push_back(8'h58);
        push_line(0);
        exp_q.push_back(8'hC0);
        l2_start = exp_q.size();
        push_line(1);
    endfunction

    function automatic void clear_log();
        strb_log.delete();
        strb_cyc.delete();
    endfunction

    task automatic cmp_frame(input string tag);
        chk({tag, "_len"}, 32'(strb_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < strb_log.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(strb_log[i]), 32'(exp_q[i]));
    endtask

    task automatic wait_frame();
        int start;
        bit ok;
        start = fd_cnt;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (fd_cnt != start) begin
                ok = 1'b1;
                break;
            end
        end
        chk("frame_done_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_strobes(input int n);
        for (int i = 0; i < 2000 && strb_log.size() < n; i++) tick();
        chk("strobes_reached", 32'(strb_log.size() >= n), 32'd1);
    endtask

    // One cycle of writes; the model applies B then A so A wins a collision.
    task automatic wr2(input logic aw, input logic [4:0] aa, input logic [7:0] ad,
                       input logic bw, input logic [4:0] ba, input logic [7:0] bd);
        a_wr = aw; {a_line, a_col} = aa; a_char = ad;
        b_wr = bw; {b_line, b_col} = ba; b_char = bd;
        tick();
        a_wr = 1'b0;
        b_wr = 1'b0;
        if (bw) model[ba] = bd;
        if (aw) model[aa] = ad;
    endtask

    task automatic pulse_refresh();
        refresh_req = 1'b1;
        tick();
        refresh_req = 1'b0;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;

        // Reset values.
        RESET = 1'b1;
        repeat (3) tick();
        chk("rst_lcdstrb", 32'(lcdstrb), 32'd0);
        chk("rst_lcd_data", 32'(Lcd_data), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_sched_busy", 32'(sched_busy), 32'd1);

        // 16 quiet MBusy cycles, one IDLE cycle, then the clear strobe:
        // counted in clocks after RESET drops, it lands on clock 17.
        RESET = 1'b0;
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (lcdstrb === 1'b1) begin
                n = i;
                break;
            end
        end
        chk("first_strb_latency", 32'(n), 32'(READY_CYC + 1));
        chk("first_strb_data", 32'(Lcd_data), 32'h58);
        build_exp();
        wait_frame();
        cmp_frame("reset_frame");
        chk("idle_after_frame", 32'(sched_busy), 32'd0);

        // Two different addresses in one cycle, with both substitutions.
        clear_log();
        wr2(1'b1, {1'b0, 4'd3}, 8'h58, 1'b1, {1'b1, 4'd0}, 8'hC0);
        build_exp();
        wait_frame();
        cmp_frame("subst_frame");
        if (strb_log.size() > 4) chk("fifth_strb_x", 32'(strb_log[4]), 32'h78);
        if (strb_log.size() > l2_start) chk("l2_first_c0", 32'(strb_log[l2_start]), 32'h20);
        if (strb_cyc.size() > 3) chk("char_gap", 32'(strb_cyc[3] - strb_cyc[2]), 32'(GUARD_CYC + 2));

        // Collision (A wins), then a write during the refresh forces a second one.
        clear_log();
        wr2(1'b1, {1'b1, 4'd5}, 8'h41, 1'b1, {1'b1, 4'd5}, 8'h42);
        wr2(1'b1, {1'b0, 4'd15}, 8'h45, 1'b1, {1'b1, 4'd15}, 8'h46);
        build_exp();
        wait_frame();
        cmp_frame("collide_frame");
        if (strb_log.size() > l2_start + 5) chk("collide_a_wins", 32'(strb_log[l2_start+5]), 32'h41);
        clear_log();
        wait_frame();
        cmp_frame("collide_rerun");

        // MBusy held high after the 3rd strobe.
        clear_log();
        build_exp();
        pulse_refresh();
        wait_strobes(3);
        MBusy = 1'b1;
        n = strb_log.size();
        repeat (100) tick();
        chk("hold_no_strobe", 32'(strb_log.size()), 32'(n));
        MBusy = 1'b0;
        tick();
        chk("resume_next_cycle", 32'(lcdstrb), 32'd1);
        wait_frame();
        cmp_frame("hold_frame");

        // Write during the 20th strobe: current frame unchanged, new frame follows.
        clear_log();
        build_exp();
        pulse_refresh();
        wait_strobes(20);
        wr2(1'b1, {1'b0, 4'd7}, 8'h51, 1'b0, 5'd0, 8'h00);
        wait_frame();
        cmp_frame("live_frame");
        chk("idle_one_cycle", 32'(sched_busy), 32'd0);
        clear_log();
        build_exp();
        tick();
        chk("refill_strb", 32'(lcdstrb), 32'd1);
        chk("refill_clr", 32'(Lcd_data), 32'h58);
        wait_frame();
        cmp_frame("refill_frame");

        // Reset during the line-2 segment.
        clear_log();
        pulse_refresh();
        wait_strobes(20);
        RESET = 1'b1;
        tick();
        chk("midrst_lcdstrb", 32'(lcdstrb), 32'd0);
        chk("midrst_busy", 32'(sched_busy), 32'd1);
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        clear_log();
        build_exp();
        wait_frame();
        cmp_frame("post_rst_frame");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
